// File: rtl/sram_arbiter.sv
// sram_arbiter: shares a single-port read Sram between IFU and LSU, with a response watchdog.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration; otherwise LSU has fixed priority.
module sram_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_data,
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  output logic        lsu_ready,
  output logic [31:0] lsu_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  // grant encoding: 0 = IFU, 1 = LSU
  logic        grant, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic        win;
  logic        timeout_hit;
  logic        resp;

  always_comb begin
`ifdef SRAM_ARB_RR_EN
    if (ifu_req && lsu_req) win = ~last_grant;
    else                    win = lsu_req;
`else
    win = lsu_req;
`endif
  end

  assign timeout_hit = (wcnt == WCNT_LAST);
  assign resp        = (state == WAIT) && (mem_ready || timeout_hit);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    mem_req_nxt    = 1'b0;
    mem_addr_nxt   = mem_addr;
    wcnt_nxt       = wcnt;
    case (state)
      IDLE: begin
        if (ifu_req || lsu_req) begin
          grant_nxt    = win;
          mem_addr_nxt = win ? lsu_addr : ifu_addr;
          mem_req_nxt  = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_nxt       = 8'd0;
        last_grant_nxt = grant;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (resp) state_nxt = IDLE;
        else      wcnt_nxt  = wcnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
      wcnt       <= 8'd0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      wcnt       <= wcnt_nxt;
    end
  end

  // Both data ports carry the same word; only the granted master's ready qualifies it.
  assign ifu_ready = resp && !grant;
  assign lsu_ready = resp && grant;
  assign ifu_data  = mem_ready ? mem_data : ERR_DATA;
  assign lsu_data  = mem_ready ? mem_data : ERR_DATA;
  assign err       = (state == WAIT) && !mem_ready && timeout_hit;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed plus randomized checks of sram_arbiter against a transaction-timeline model.
module tb_sram_arbiter;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req = 1'b0, lsu_req = 1'b0, mem_ready = 1'b0;
  logic [31:0] ifu_addr = '0, lsu_addr = '0, mem_data = '0;
  logic        ifu_ready, lsu_ready, mem_req, err;
  logic [31:0] ifu_data, lsu_data, mem_addr;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready), .ifu_data(ifu_data),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_ready(lsu_ready), .lsu_data(lsu_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: age counts cycles since the grant decision (-1 = no transaction).
  // age 1 is the issue cycle; from age 2 a response may arrive; age TO+1 is the forced timeout.
  int          age        = -1;
  logic        owner      = 1'b0;
  logic        last_owner = 1'b1;
  logic [31:0] m_addr     = '0;
  logic        exp_ifu_rdy, exp_lsu_rdy;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic ir, input logic lr);
    if (ir && lr) begin
`ifdef SRAM_ARB_RR_EN
      return !last_owner;
`else
      return 1'b1;
`endif
    end
    return lr;
  endfunction

  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la,
                      input logic mr, input logic [31:0] md, input logic rs);
    logic done;
    @(negedge clk);
    ifu_req = ir; ifu_addr = ia; lsu_req = lr; lsu_addr = la;
    mem_ready = mr; mem_data = md; rst = rs;
    #1;
    done = (age >= 2) && (mr || age == TO + 1);
    exp_ifu_rdy = done && !owner;
    exp_lsu_rdy = done && owner;
    if (chk_en) begin
      check_val("mem_req",   32'(mem_req),   32'(age == 1));
      check_val("mem_addr",  mem_addr,       m_addr);
      check_val("ifu_ready", 32'(ifu_ready), 32'(exp_ifu_rdy));
      check_val("lsu_ready", 32'(lsu_ready), 32'(exp_lsu_rdy));
      check_val("err",       32'(err),       32'(done && !mr));
      if (exp_ifu_rdy) check_val("ifu_data", ifu_data, mr ? md : ERR);
      if (exp_lsu_rdy) check_val("lsu_data", lsu_data, mr ? md : ERR);
    end
    if (!rs) begin
      age = -1; m_addr = '0; last_owner = 1'b1;
    end else if (age == -1) begin
      if (ir || lr) begin
        owner  = pick(ir, lr);
        m_addr = owner ? la : ia;
        age    = 1;
      end
    end else if (age == 1) begin
      last_owner = owner;
      age = 2;
    end else if (done) begin
      age = -1;
    end else begin
      age++;
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          k;
    logic        ord[4];
    logic        exp_ord[4];
    int          nresp;
    logic        ip, lp, mr, rs;
    logic [31:0] ia, la;
    int          silent;

`ifdef SRAM_ARB_RR_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset: outputs before the model takes over are unchecked.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Single IFU read
    step(1, 32'h8000_0000, 0, 0, 0, 0, 1);
    step(1, 32'h8000_0000, 0, 0, 0, 0, 1);
    step(1, 32'h8000_0000, 0, 0, 1, 32'h0000_0413, 1);
    check_val("single_ifu_ready", 32'(ifu_ready), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Spurious response in IDLE
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, $urandom, 1);

    // LSU timeout
    k = 0;
    while (k < 20) begin
      step(0, 0, 1, 32'h0000_2000, 0, $urandom, 1);
      if (lsu_ready) break;
      k++;
    end
    check_val("timeout_lat", 32'(k), 32'(TO + 1));
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset mid-WAIT, late Sram response, then normal IFU read
    step(1, 32'h0000_0100, 0, 0, 0, 0, 1);
    step(1, 32'h0000_0100, 0, 0, 0, 0, 1);
    step(1, 32'h0000_0100, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678, 1);
    check_val("post_rst_addr", mem_addr, 32'd0);
    k = 0;
    while (k < 20) begin
      step(1, 32'h0000_0200, 0, 0, 1, 32'hA5A5_0001, 1);
      if (ifu_ready) break;
      k++;
    end
    check_val("post_rst_lat", 32'(k), 32'd2);

    // Back-to-back IFU: next request at address+4 one cycle after ready
    k = 0;
    while (k < 20) begin
      step(1, 32'h0000_0300, 0, 0, 1, 32'h0000_0111, 1);
      if (ifu_ready) break;
      k++;
    end
    k = 1;
    while (k < 20) begin
      step(1, 32'h0000_0304, 0, 0, 0, 0, 1);
      if (mem_req) break;
      k++;
    end
    check_val("b2b_gap", 32'(k), 32'd2);
    check_val("b2b_addr", mem_addr, 32'h0000_0304);
    step(1, 32'h0000_0304, 0, 0, 1, 32'h0000_0222, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Contention from reset
    step(0, 0, 0, 0, 0, 0, 0);
    nresp = 0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      step(1, 32'h8000_0000, 1, 32'h8000_1000, 1, $urandom, 1);
      if (ifu_ready || lsu_ready) begin
        ord[nresp] = lsu_ready;
        nresp++;
      end
    end
    check_val("contention_count", 32'(nresp), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < nresp) check_val($sformatf("contention_grant%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    ip = 0; lp = 0; ia = 0; la = 0; silent = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = $urandom; end
      if (!lp && $urandom_range(0, 2) == 0) begin lp = 1; la = $urandom; end
      mr = (silent > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (silent > 0) silent--;
      else if ($urandom_range(0, 99) == 0) silent = 10;
      rs = ($urandom_range(0, 149) != 0);
      step(ip, ia, lp, la, mr, $urandom, rs);
      if (exp_ifu_rdy || !rs) ip = 0;
      if (exp_lsu_rdy || !rs) lp = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
